// File: rtl/tt7_pkg.sv
// tt7_pkg: shared types and sizes for the 7-input truth-table sweeper.
package tt7_pkg;

    // Sweeper control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Number of FUT inputs, number of minterms, and width of the ones-count.
    localparam int N_IN   = 7;
    localparam int N_MINT = 128;
    localparam int ONES_W = 8;

endpackage

// File: rtl/tt7_sweep.sv
// tt7_sweep: walks all 128 minterms of a 7-input combinational function,
// holds each one for SETTLE+1 cycles, samples the function output on the
// last cycle and builds the 128-bit truth table plus its ones-count.
// The result is offered on a valid/ready handshake.
module tt7_sweep
    import tt7_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x_o,
    input  logic              f_i,
    output logic              busy,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic [N_MINT-1:0] tt_data,
    output logic [ONES_W-1:0] tt_ones
);

    // Reload value of the per-minterm hold counter; SETTLE is limited to 0..15.
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t            state;
    state_t            state_next;
    logic [N_IN-1:0]   idx;
    logic [3:0]        wait_cnt;
    logic              sample_now;

    // A sample happens on the last hold cycle of the current minterm.
    assign sample_now = (state == SWEEP) && (wait_cnt == 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = SWEEP;
                    end
                end
                SWEEP: begin
                    if (sample_now && (idx == 7'd127)) begin
                        state_next = OUT;
                    end
                end
                OUT: begin
                    if (tt_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Minterm index, hold counter and result accumulation; the index wraps
    // back to 0 after the final sample so x_o is already 0 in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            wait_cnt <= '0;
            tt_data  <= '0;
            tt_ones  <= '0;
        end else if (abort) begin
            idx      <= '0;
            wait_cnt <= '0;
            tt_data  <= '0;
            tt_ones  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        wait_cnt <= SETTLE_CNT;
                        tt_data  <= '0;
                        tt_ones  <= '0;
                    end
                end
                SWEEP: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        tt_data[idx] <= f_i;
                        tt_ones      <= tt_ones + {{(ONES_W-1){1'b0}}, f_i};
                        idx          <= idx + 7'd1;
                        wait_cnt     <= SETTLE_CNT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        x_o      = idx;
        busy     = (state != IDLE);
        tt_valid = (state == OUT);
    end

endmodule

// File: tb/tb_tt7_sweep.sv
// tb_tt7_sweep: drives three sweeper instances (SETTLE = 1, 0, 3) with
// behavioural FUT models that only produce a correct output once their
// input has been stable for SETTLE cycles, and checks the signatures.
module tb_tt7_sweep;
    import tt7_pkg::*;

    localparam int N_DUT = 3;
    localparam int SETTLE_TAB [N_DUT] = '{1, 0, 3};

    typedef struct {
        int           dut;
        int           sel;
        int           delay;
        bit           pulse;
        logic [127:0] exp_tt;
        logic [7:0]   exp_ones;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start    [N_DUT];
    logic         abort    [N_DUT];
    logic         f_i      [N_DUT];
    logic         busy     [N_DUT];
    logic         tt_valid [N_DUT];
    logic         tt_ready [N_DUT];
    logic [6:0]   x_o      [N_DUT];
    logic [127:0] tt_data  [N_DUT];
    logic [7:0]   tt_ones  [N_DUT];
    int           fut_sel  [N_DUT];
    logic [127:0] rand_tbl [N_DUT];
    logic [4:0]   age      [N_DUT] = '{default: 5'd31};
    logic [6:0]   last_x   [N_DUT] = '{default: 7'd0};

    int n_checks = 0;
    int n_err    = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference FUT functions of the 7-bit minterm.
    function automatic logic fut_ref(input int sel, input int x, input logic [127:0] tbl);
        logic [6:0] v;
        v = 7'(x);
        case (sel)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            3:       return v[6];
            4:       return tbl[v];
            5:       return ^v;
            default: return (v[0] & v[3]) | v[5];
        endcase
    endfunction

    // Instances plus their FUT models; an FUT output is inverted until its
    // input has been stable long enough, so early sampling is visible.
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        tt7_sweep #(.SETTLE(SETTLE_TAB[g])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .abort    (abort[g]),
            .x_o      (x_o[g]),
            .f_i      (f_i[g]),
            .busy     (busy[g]),
            .tt_valid (tt_valid[g]),
            .tt_ready (tt_ready[g]),
            .tt_data  (tt_data[g]),
            .tt_ones  (tt_ones[g])
        );

        assign f_i[g] = (age[g] >= 5'(SETTLE_TAB[g]))
                        ?  fut_ref(fut_sel[g], int'(x_o[g]), rand_tbl[g])
                        : ~fut_ref(fut_sel[g], int'(x_o[g]), rand_tbl[g]);

        // Track how many cycles the FUT input has been stable.
        always @(negedge clk) begin
            if (x_o[g] != last_x[g]) begin
                last_x[g] <= x_o[g];
                age[g]    <= 5'd0;
            end else if (age[g] != 5'd31) begin
                age[g] <= age[g] + 5'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start a sweep on instance d and wait (bounded) for tt_valid.
    task automatic applyStimulus(input int d, input int sel, output int lat, output int xo_bad);
        int s;
        s = SETTLE_TAB[d];
        fut_sel[d]  = sel;
        tt_ready[d] = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        checkOutput("busy after start", 128'(busy[d]), 128'd1);
        checkOutput("x_o after start", 128'(x_o[d]), 128'd0);
        lat    = 0;
        xo_bad = 0;
        while (!tt_valid[d] && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (!tt_valid[d]) begin
                if (x_o[d] != 7'((lat / (s + 1)) % 128) || !busy[d]) xo_bad++;
            end
        end
    endtask

    // Full sweep plus handshake with optional backpressure and stray starts.
    task automatic runCase(input int d, input int sel, input int delay, input bit pulse,
                           input logic [127:0] exp_tt, input logic [7:0] exp_ones, input int exp_lat);
        int lat;
        int xo_bad;
        int hold_bad;
        applyStimulus(d, sel, lat, xo_bad);
        checkOutput("latency", 128'(lat), 128'(exp_lat));
        checkOutput("x_o sequence", 128'(xo_bad), 128'd0);
        checkOutput("tt_valid", 128'(tt_valid[d]), 128'd1);
        checkOutput("tt_data", tt_data[d], exp_tt);
        checkOutput("tt_ones", 128'(tt_ones[d]), 128'(exp_ones));
        checkOutput("x_o in OUT", 128'(x_o[d]), 128'd0);
        hold_bad = 0;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            start[d] = pulse && (k == 2);
            @(posedge clk);
            #1;
            if (!tt_valid[d] || !busy[d] || tt_data[d] !== exp_tt || tt_ones[d] !== exp_ones) hold_bad++;
        end
        if (delay > 0) checkOutput("hold under backpressure", 128'(hold_bad), 128'd0);
        @(negedge clk);
        tt_ready[d] = 1'b1;
        start[d]    = pulse;
        @(posedge clk);
        #1;
        tt_ready[d] = 1'b0;
        checkOutput("tt_valid after handshake", 128'(tt_valid[d]), 128'd0);
        checkOutput("busy after handshake", 128'(busy[d]), 128'd0);
        if (pulse) begin
            @(negedge clk);
            start[d] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("no queued start", 128'(busy[d]), 128'd0);
        end
        start[d] = 1'b0;
    endtask

    initial begin
        vec_t         vecs [5];
        logic [127:0] m_tt;
        int           n;
        int           seen;

        vecs[0] = '{0, 2, 0,  1'b0, {16{8'hE8}},                    8'd64,  256};
        vecs[1] = '{1, 0, 1,  1'b0, 128'd0,                         8'd0,   128};
        vecs[2] = '{1, 1, 0,  1'b0, {128{1'b1}},                    8'd128, 128};
        vecs[3] = '{2, 3, 2,  1'b0, {{64{1'b1}}, {64{1'b0}}},       8'd64,  512};
        vecs[4] = '{0, 2, 10, 1'b1, {16{8'hE8}},                    8'd64,  256};

        for (int i = 0; i < N_DUT; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; tt_ready[i] = 1'b0;
            fut_sel[i] = 0; rand_tbl[i] = '0;
        end
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < N_DUT; i++) begin
            checkOutput("reset busy", 128'(busy[i]), 128'd0);
            checkOutput("reset tt_valid", 128'(tt_valid[i]), 128'd0);
            checkOutput("reset x_o", 128'(x_o[i]), 128'd0);
            checkOutput("reset tt_ones", 128'(tt_ones[i]), 128'd0);
            checkOutput("reset tt_data", tt_data[i], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table-driven sweeps");
        for (int v = 0; v < 5; v++) begin
            runCase(vecs[v].dut, vecs[v].sel, vecs[v].delay, vecs[v].pulse,
                    vecs[v].exp_tt, vecs[v].exp_ones, vecs[v].exp_lat);
        end

        $display("[TB] abort mid-sweep");
        fut_sel[0] = 2;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n = 0;
        while (x_o[0] != 7'd50 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached x_o 50", 128'(x_o[0]), 128'd50);
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0] = 1'b0;
        checkOutput("abort busy", 128'(busy[0]), 128'd0);
        checkOutput("abort x_o", 128'(x_o[0]), 128'd0);
        checkOutput("abort tt_ones", 128'(tt_ones[0]), 128'd0);
        checkOutput("abort tt_data", tt_data[0], 128'd0);
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (tt_valid[0] || busy[0]) seen++;
        end
        checkOutput("no result after abort", 128'(seen), 128'd0);
        runCase(0, 2, 1, 1'b0, {16{8'hE8}}, 8'd64, 256);

        $display("[TB] asynchronous reset mid-sweep");
        fut_sel[0] = 3;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n = 0;
        while (x_o[0] != 7'd90 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached x_o 90", 128'(x_o[0]), 128'd90);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 128'(busy[0]), 128'd0);
        checkOutput("async reset x_o", 128'(x_o[0]), 128'd0);
        checkOutput("async reset tt_ones", 128'(tt_ones[0]), 128'd0);
        checkOutput("async reset tt_data", tt_data[0], 128'd0);
        checkOutput("async reset tt_valid", 128'(tt_valid[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runCase(0, 3, 0, 1'b0, {{64{1'b1}}, {64{1'b0}}}, 8'd64, 256);

        $display("[TB] randomized sweeps");
        for (int it = 0; it < 12; it++) begin
            int d;
            int sel;
            d   = int'($urandom_range(0, N_DUT - 1));
            sel = int'($urandom_range(0, 6));
            rand_tbl[d] = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 128; i++) m_tt[i] = fut_ref(sel, i, rand_tbl[d]);
            runCase(d, sel, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    m_tt, 8'($countones(m_tt)), 128 * (SETTLE_TAB[d] + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
